// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmit byte stream between NumReq valid/ready requesters.
// A grant is held for a whole packet and can be revoked when the owner stalls too long.
module uart_tx_arbiter #(
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 1024
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_ni,
    input  logic [NumReq-1:0]   req_valid_i,
    input  logic [NumReq*8-1:0] req_data_i,
    input  logic [NumReq-1:0]   req_last_i,
    output logic [NumReq-1:0]   req_ready_o,
    output logic                tx_valid_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_ready_i,
    output logic [NumReq-1:0]   grant_o,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int OwnW = $clog2(NumReq);
    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e            state_q, state_d;
    logic [OwnW-1:0]   owner_q, owner_d;
    logic [OwnW-1:0]   last_owner_q, last_owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              timeout_d;
    logic [NumReq-1:0] grant_d;
    logic [OwnW-1:0]   pick;
    logic              owner_valid;
    logic              owner_xfer;

    assign owner_valid = req_valid_i[owner_q];
    assign owner_xfer  = owner_valid && tx_ready_i;

    // Requesters above last_owner beat those at or below it; lowest index wins within each group.
    always_comb begin
        pick = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (OwnW'(i) <= last_owner_q)) begin
                pick = OwnW'(i);
            end
        end
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (OwnW'(i) > last_owner_q)) begin
                pick = OwnW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        tx_valid_o   = 1'b0;
        tx_data_o    = 8'h00;
        req_ready_o  = '0;

        if (state_q == IDLE) begin
            cnt_d = '0;
            if (|req_valid_i) begin
                state_d = LOCKED;
                owner_d = pick;
            end
        end else begin
            tx_valid_o           = owner_valid;
            tx_data_o            = req_data_i[{owner_q, 3'b000} +: 8];
            req_ready_o[owner_q] = tx_ready_i;

            if (owner_valid) begin
                cnt_d = '0;
                if (owner_xfer && req_last_i[owner_q]) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end else if (TimeoutCycles > 0) begin
                // Only cycles with the owner idle count; backpressure never does.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                    timeout_d    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_d = '0;
        if (state_d == LOCKED) begin
            grant_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OwnW'(NumReq - 1);
            cnt_q        <= '0;
            timeout_o    <= 1'b0;
            grant_o      <= '0;
            busy_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            timeout_o    <= timeout_d;
            grant_o      <= grant_d;
            busy_o       <= (state_d == LOCKED);
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit channel between `NumReq` byte-stream requesters, such as the Ibex UART peripheral and a debug/boot message source, so that they can drive one board UART_TX pin. Arbitration is round-robin at packet granularity. The winning requester keeps the channel until it completes a byte marked `last`, or until it stalls past a timeout. The block sits between the requesters and the UART transmitter, in the `clk_sys` domain.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters, ≥2.
- `TimeoutCycles`, default 1024: idle cycles after which a stalled owner loses the grant; 0 disables the timeout.

Ports:
- `clk_sys_i`  in  1  system clock; the only clock.
- `rst_sys_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NumReq  per-requester byte valid.
- `req_data_i`  in  NumReq*8  per-requester byte; requester i uses bits [8i+7:8i].
- `req_last_i`  in  NumReq  byte is the final byte of its packet.
- `req_ready_o`  out  NumReq  byte accepted from requester i.
- `tx_valid_o`  out  1  byte valid towards the UART transmitter.
- `tx_data_o`  out  8  byte towards the UART transmitter.
- `tx_ready_i`  in  1  UART transmitter accepts the byte.
- `grant_o`  out  NumReq  one-hot current owner; all zero when idle.
- `busy_o`  out  1  a packet is in progress (state LOCKED).
- `timeout_o`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Handshake is valid/ready. A transfer occurs on a cycle where valid and ready are both 1. Requesters must hold valid, data and last stable until ready.
- The block has two states, IDLE and LOCKED, plus a registered `owner` index, a registered `last_owner` index and a timeout counter.
- **Reset:** state IDLE, `last_owner` = NumReq-1 (requester 0 wins first), counter 0. All outputs are 0.
- **IDLE:**
  - All `req_ready_o` are 0; `tx_valid_o` and `tx_data_o` are 0.
  - If any `req_valid_i` is set, pick the first valid index searching upward from `last_owner`+1, wrapping modulo NumReq.
  - Next state is LOCKED with `owner` = the picked index.
- **LOCKED** (combinational pass-through from the owner):
  - `tx_valid_o` = `req_valid_i[owner]`.
  - `tx_data_o` = owner's byte.
  - `req_ready_o[owner]` = `tx_ready_i`; all other bits of `req_ready_o` are 0.
  - `grant_o` = one-hot(owner); `busy_o` = 1.
- **Normal release:** a transfer with `req_last_i[owner]` = 1 sets next state to IDLE and `last_owner` to `owner`.
- **Timeout:**
  - Applies only when TimeoutCycles > 0.
  - The counter increments in LOCKED on every cycle where `req_valid_i[owner]` = 0.
  - It clears on any cycle where the owner is valid, and on entry to LOCKED.
  - Cycles with owner valid and `tx_ready_i` low are backpressure and never count.
  - When the counter reaches TimeoutCycles: next state is IDLE, `last_owner` = `owner`, and `timeout_o` = 1 for exactly that one cycle (registered).
  - Counter width is $clog2(TimeoutCycles+1).
  - A timeout and a transfer cannot occur in the same cycle, because a transfer requires the owner to be valid.
- A bit of `req_valid_i` set for a non-owner has no effect until re-arbitration.
- Reset asserted mid-packet returns the block to IDLE immediately. Any partially sent packet is abandoned; the downstream UART is responsible for dropping it.

## Timing
- **Grant latency:** a request seen in IDLE at cycle N gives `grant_o`, `busy_o` and a pass-through `tx_valid_o` at N+1.
- **Data path:** pass-through in LOCKED adds no latency. A transfer can occur every cycle.
- **Packet gap:** a `last` transfer at cycle N returns the block to IDLE at N+1, and the next grant appears at N+2.
- **Timeout:**
  - With the owner invalid from cycle M onward, the counter equals TimeoutCycles at the clock edge ending cycle M+TimeoutCycles-1.
  - `timeout_o` = 1 and state = IDLE during cycle M+TimeoutCycles.
- **Registered outputs:** `grant_o`, `busy_o` and `timeout_o` are registered.
- **Combinational outputs:** `tx_valid_o`, `tx_data_o` and `req_ready_o` are combinational from the registered owner and the inputs.

## Test plan
- **Single packet:** req0 sends bytes 0x41, 0x42, 0x43 (last on 0x43) with `tx_ready_i`=1 and valid from cycle 0 → `grant_o`=01 from cycle 1, bytes on `tx_data_o` in cycles 1–3, `grant_o`=00 at cycle 4.
- **Round-robin:** req0 and req1 both hold 2-byte packets continuously after reset → grant order req0, req1, req0, req1, with a 2-cycle gap after each `last`.
- **Backpressure:** owner valid with 0x55 and `tx_ready_i`=0 for 5000 cycles (TimeoutCycles=1024) → no `timeout_o`, `tx_data_o` stays at 0x55, `req_ready_o` stays 0.
- **Timeout:** TimeoutCycles=16; req0 sends one non-last byte, then drops valid; req1 is pending → `timeout_o` pulses 16 cycles after the drop, then `grant_o`=10 one cycle later.
- **Reset mid-packet:** assert `rst_sys_ni`=0 asynchronously mid-packet → all outputs are 0 with no clock edge. After release, with req0 and req1 both valid, req0 is granted first.
- **Re-grant:** req0 sends back-to-back single-byte `last` packets and req1 is idle → req0 is re-granted each time, one byte every 2 cycles.
